// File: rtl/trivium_comp.sv
// trivium_comp: Trivium keystream core (80-bit key, 80-bit IV, 288-bit state).
// One 128-bit keystream block per accepted IV; UNROLL rounds per clock.
// Build option: TRIVIUM_DOUT_CLR_EN clears Dout when a new IV is accepted.
// Without it, Dout keeps the previous block until the next DONE.
// State bit s(i) of the Trivium description is held in s[i-1].
module trivium_comp #(
  parameter int unsigned UNROLL = 1
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         EN,
  input  logic [79:0]  Kin,
  input  logic [79:0]  Din,
  input  logic         Krdy,
  input  logic         Drdy,
  input  logic         EncDec,
  output logic [127:0] Dout,
  output logic         BSY,
  output logic         Kvld,
  output logic         Dvld
);

  localparam int unsigned N_INIT = 1152 / UNROLL;
  localparam int unsigned N_OUT  = 128 / UNROLL;

  typedef enum logic [1:0] {IDLE, INIT, GEN, DONE} state_t;

  state_t              st;
  logic [10:0]         cnt;
  logic [79:0]         key;
  logic [287:0]        s;
  logic [287:0]        s_nxt;
  logic [127:0]        ksbuf;
  logic [UNROLL-1:0]   zb;
  logic [287:0]        v;
  logic                t1, t2, t3;

  // Keystream is the same for encrypt and decrypt, so EncDec has no function.
  logic unused_encdec;
  assign unused_encdec = EncDec;

  // UNROLL Trivium rounds chained combinationally; first z lands in zb MSB.
  always_comb begin
    v  = s;
    zb = '0;
    t1 = 1'b0;
    t2 = 1'b0;
    t3 = 1'b0;
    for (int unsigned r = 0; r < UNROLL; r++) begin
      t1 = v[65]  ^ v[92];
      t2 = v[161] ^ v[176];
      t3 = v[242] ^ v[287];
      zb[UNROLL-1-r] = t1 ^ t2 ^ t3;
      t1 = t1 ^ (v[90]  & v[91])  ^ v[170];
      t2 = t2 ^ (v[174] & v[175]) ^ v[263];
      t3 = t3 ^ (v[285] & v[286]) ^ v[68];
      v  = {v[286:177], t2, v[175:93], t1, v[91:0], t3};
    end
    s_nxt = v;
  end

  // Control FSM, key register, cipher state and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      st    <= IDLE;
      cnt   <= '0;
      key   <= '0;
      s     <= '0;
      ksbuf <= '0;
      Dout  <= '0;
      BSY   <= 1'b0;
      Kvld  <= 1'b0;
      Dvld  <= 1'b0;
    end else if (!EN) begin
      Kvld <= 1'b0;
      Dvld <= 1'b0;
    end else begin
      Kvld <= 1'b0;
      Dvld <= 1'b0;
      case (st)
        IDLE: begin
          if (Krdy) begin
            key  <= Kin;
            Kvld <= 1'b1;
          end else if (Drdy) begin
            s   <= {3'b111, 112'b0, Din, 13'b0, key};
            cnt <= '0;
            BSY <= 1'b1;
            st  <= INIT;
`ifdef TRIVIUM_DOUT_CLR_EN
            Dout <= '0;
`endif
          end
        end
        INIT: begin
          s <= s_nxt;
          if (cnt == 11'(N_INIT - 1)) begin
            cnt <= '0;
            st  <= GEN;
          end else begin
            cnt <= cnt + 11'd1;
          end
        end
        GEN: begin
          s     <= s_nxt;
          ksbuf <= {ksbuf[127-UNROLL:0], zb};
          if (cnt == 11'(N_OUT - 1)) begin
            cnt <= '0;
            st  <= DONE;
          end else begin
            cnt <= cnt + 11'd1;
          end
        end
        DONE: begin
          Dout <= ksbuf;
          Dvld <= 1'b1;
          BSY  <= 1'b0;
          st   <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trivium_comp.sv
// Directed/random bench for trivium_comp (UNROLL=1) with a bit-level Trivium model.
module tb_trivium_comp;

  logic         clk = 1'b0;
  logic         rst, en, krdy, drdy, encdec;
  logic [79:0]  kin, din;
  logic [127:0] dout;
  logic         bsy, kvld, dvld;

  int n_assert = 0;
  int n_fail   = 0;

  trivium_comp #(.UNROLL(1)) dut (
    .CLK(clk), .RST(rst), .EN(en), .Kin(kin), .Din(din),
    .Krdy(krdy), .Drdy(drdy), .EncDec(encdec),
    .Dout(dout), .BSY(bsy), .Kvld(kvld), .Dvld(dvld)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Trivium per the textbook description, 1-based state s1..s288.
  function automatic logic [127:0] ref_ks(input logic [79:0] k, input logic [79:0] iv);
    bit s [1:288];
    bit a, b, c, z;
    logic [127:0] ks;
    ks = '0;
    for (int i = 1; i <= 288; i++) s[i] = 1'b0;
    for (int i = 0; i < 80; i++) begin
      s[i+1]  = k[i];
      s[i+94] = iv[i];
    end
    s[286] = 1'b1; s[287] = 1'b1; s[288] = 1'b1;
    for (int r = 0; r < 1280; r++) begin
      a = s[66]  ^ s[93];
      b = s[162] ^ s[177];
      c = s[243] ^ s[288];
      z = a ^ b ^ c;
      a = a ^ (s[91]  & s[92])  ^ s[171];
      b = b ^ (s[175] & s[176]) ^ s[264];
      c = c ^ (s[286] & s[287]) ^ s[69];
      for (int i = 93;  i >= 2;   i--) s[i] = s[i-1];
      s[1] = c;
      for (int i = 177; i >= 95;  i--) s[i] = s[i-1];
      s[94] = a;
      for (int i = 288; i >= 179; i--) s[i] = s[i-1];
      s[178] = b;
      if (r >= 1152) ks[127-(r-1152)] = z;
    end
    return ks;
  endfunction

  // mode: 0 plain, 1 hold Drdy with X on Din, 2 EN gap of 50, 3 Krdy poke while busy
  task automatic do_run(input logic [79:0] iv, input int mode,
                        output int lat, output logic [127:0] d, output bit ok);
    din  = iv;
    drdy = 1'b1;
    tick();
    if (mode == 1) din = 'x;
    else drdy = 1'b0;
    lat = 0;
    ok  = 1'b1;
    d   = '0;
    while (lat < 3000) begin
      tick();
      lat++;
      if (dvld) begin
        d = dout;
        if (bsy) ok = 1'b0;
        break;
      end
      if (!bsy || kvld) ok = 1'b0;
      if (mode == 2 && lat == 300) begin
        en = 1'b0;
        repeat (50) begin
          tick();
          lat++;
          if (!bsy || dvld) ok = 1'b0;
        end
        en = 1'b1;
      end
      if (mode == 3 && lat == 100) begin
        kin  = ~kin;
        krdy = 1'b1;
      end
      if (mode == 3 && lat == 101) begin
        krdy = 1'b0;
        kin  = ~kin;
      end
    end
    drdy = 1'b0;
  endtask

  initial begin
    logic [79:0]  cur_key, iv0, iv1, k2;
    logic [127:0] d, d0, exp0;
    int           lat;
    bit           ok;

    rst = 1'b1; en = 1'b1; krdy = 1'b0; drdy = 1'b0; encdec = 1'b0;
    kin = '0; din = '0;
    tick();
    check("rst_dout", dout, '0);
    check("rst_bsy",  128'(bsy),  '0);
    check("rst_kvld", 128'(kvld), '0);
    check("rst_dvld", 128'(dvld), '0);
    rst = 1'b0;

    // Key load with EN low is ignored.
    en = 1'b0; krdy = 1'b1; kin = 80'h1234;
    tick();
    check("en0_kvld", 128'(kvld), '0);
    en = 1'b1; kin = '0;
    tick();
    krdy = 1'b0;
    check("kload_kvld", 128'(kvld), 128'd1);
    check("kload_bsy",  128'(bsy),  '0);
    tick();
    check("kload_kvld_pulse", 128'(kvld), '0);
    cur_key = '0;

    iv0  = 80'h00010203040506070809;
    exp0 = ref_ks(cur_key, iv0);
    do_run(iv0, 0, lat, d0, ok);
    check("run_lat",  128'(lat), 128'd1281);
    check("run_dout", d0, exp0);
    check("run_bsy",  128'(ok),  128'd1);
    tick();
    check("run_dvld_pulse", 128'(dvld), '0);
    check("run_dout_hold",  dout, exp0);

    // Drdy held through the run with Din scrambled: no restart, same block.
    do_run(iv0, 1, lat, d, ok);
    check("hold_lat",  128'(lat), 128'd1281);
    check("hold_dout", d, exp0);
    check("hold_ok",   128'(ok), 128'd1);
    tick();
    check("hold_norestart", 128'(bsy), '0);

    // Reset mid-run, then a fresh run gives the uninterrupted result.
    din = iv0; drdy = 1'b1;
    tick();
    drdy = 1'b0;
    repeat (599) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_bsy",  128'(bsy), '0);
    check("midrst_dout", dout, '0);
    do_run(iv0, 0, lat, d, ok);
    check("midrst_rerun", d, exp0);

    // EN low for 50 cycles during INIT delays completion by exactly 50.
    do_run(iv0, 2, lat, d, ok);
    check("engap_lat",  128'(lat), 128'd1331);
    check("engap_dout", d, exp0);
    check("engap_ok",   128'(ok), 128'd1);

    // Random keys and IVs against the model; second run pokes Krdy while busy.
    for (int n = 0; n < 2; n++) begin
      cur_key = {16'($urandom), $urandom, $urandom};
      iv1     = {16'($urandom), $urandom, $urandom};
      kin = cur_key; krdy = 1'b1;
      tick();
      krdy = 1'b0;
      check("rnd_kvld", 128'(kvld), 128'd1);
      do_run(iv1, (n == 1) ? 3 : 0, lat, d, ok);
      check("rnd_lat",  128'(lat), 128'd1281);
      check("rnd_dout", d, ref_ks(cur_key, iv1));
      check("rnd_ok",   128'(ok), 128'd1);
    end

    // Krdy and Drdy together in IDLE: key loads, no run starts.
    k2  = {16'($urandom), $urandom, $urandom};
    iv1 = {16'($urandom), $urandom, $urandom};
    kin = k2; din = iv1; krdy = 1'b1; drdy = 1'b1;
    tick();
    krdy = 1'b0; drdy = 1'b0;
    check("both_kvld", 128'(kvld), 128'd1);
    tick();
    check("both_bsy", 128'(bsy), '0);
    do_run(iv1, 0, lat, d, ok);
    check("both_dout", d, ref_ks(k2, iv1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
